green_ldst_unit: RTL and testbench

- Parametrised load/store execution unit; the successor to the fixed 16-bit green LD/RAM datapath.
- Accepts one opcode per transaction over a valid/ready handshake and decodes it.
- Performs load, store, add-store and load-add against a local synchronous single-port RAM.
- Returns load results over a second valid/ready handshake with back-pressure.
- Sits between the beamformer instruction sequencer and the sample/coefficient path.

---
 rtl/green_pkg.sv | 34 +++
 rtl/green_ram.sv | 25 ++
 rtl/green_ldst_unit.sv | 112 +++++++++++
 tb/tb_green_ldst_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/green_pkg.sv
// rtl/green_pkg.sv - shared types and opcode field helpers for the green load/store unit
package green_pkg;

  localparam int OP_FIELD_W = 4;

  typedef enum logic [OP_FIELD_W-1:0] {
    OP_NOP   = 4'd0,
    OP_LD    = 4'd1,
    OP_ST    = 4'd2,
    OP_ADDST = 4'd3,
    OP_LDADD = 4'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Operation field occupies the top OP_FIELD_W bits of the opcode word.
  function automatic int op_lsb(input int op_w);
    return op_w - OP_FIELD_W;
  endfunction

  // Address field occupies the low addr_w bits; op_w must leave room for the op field.
  function automatic int addr_msb(input int op_w, input int addr_w);
    return (addr_w <= op_w - OP_FIELD_W) ? addr_w - 1 : op_w - OP_FIELD_W - 1;
  endfunction

  function automatic logic op_is_legal(input logic [OP_FIELD_W-1:0] code);
    return code <= OP_LDADD;
  endfunction

endpackage

// File: rtl/green_ram.sv
// rtl/green_ram.sv - single-port RAM, synchronous write, registered read
module green_ram
  import green_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read is old-data on a same-address write; the unit never relies on that case.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/green_ldst_unit.sv
// rtl/green_ldst_unit.sv - load/store execution unit with local RAM and valid/ready handshakes
module green_ldst_unit
  import green_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OP_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opCode,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] B_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A_out,
  output logic              carry_out,
  output logic              err
);

  localparam int OP_LSB   = op_lsb(OP_W);
  localparam int ADDR_MSB = addr_msb(OP_W, ADDR_W);

  state_e state_q, state_d;

  logic [OP_FIELD_W-1:0] op_code;
  logic [ADDR_W-1:0]     addr;
  logic                  accept;
  logic                  is_load;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;
  logic [DATA_W-1:0]     b_q;
  logic                  ldadd_q;
  logic [DATA_W:0]       sum;
  logic [DATA_W-1:0]     a_out_q;
  logic                  carry_q;
  logic                  err_q;
  logic                  unused_opcode_bits;

  assign op_code            = opCode[OP_LSB +: OP_FIELD_W];
  assign addr               = opCode[ADDR_MSB:0];
  assign unused_opcode_bits = ^opCode;
  assign accept             = in_valid && in_ready;
  assign is_load            = (op_code == OP_LD) || (op_code == OP_LDADD);
  assign ram_we             = accept && ((op_code == OP_ST) || (op_code == OP_ADDST));
  assign ram_wdata          = (op_code == OP_ADDST) ? A_in + B_in : A_in;
  assign sum                = {1'b0, ram_rdata} + {1'b0, b_q};

  // The read is issued from the live opcode address on the accept edge; it
  // is only consumed in READ, so later reads of garbage addresses are harmless.
  green_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_load) state_d = S_READ;
      S_READ:  state_d = S_RESP;
      S_RESP:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q     <= '0;
      ldadd_q <= 1'b0;
      a_out_q <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !op_is_legal(op_code);
      if (accept && is_load) begin
        b_q     <= B_in;
        ldadd_q <= (op_code == OP_LDADD);
      end
      if (state_q == S_READ) begin
        a_out_q <= ldadd_q ? sum[DATA_W-1:0] : ram_rdata;
        carry_q <= ldadd_q && sum[DATA_W];
      end
    end
  end

  assign A_out     = a_out_q;
  assign carry_out = carry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_green_ldst_unit.sv
// tb/tb_green_ldst_unit.sv - self-checking bench for green_ldst_unit against a memory-array model
module tb_green_ldst_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] opCode = '0;
  logic [15:0] A_in = '0;
  logic [15:0] B_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] A_out;
  logic        carry_out;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [15:0] mem_m [256];

  always #5 clk = ~clk;

  green_ldst_unit #(.DATA_W(16), .ADDR_W(8), .OP_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opCode    (opCode),
    .A_in      (A_in),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_out     (A_out),
    .carry_out (carry_out),
    .err       (err)
  );

  function automatic logic [15:0] mk_op(input int code, input int addr);
    logic [3:0] junk;
    junk = 4'($urandom);
    return {code[3:0], junk, addr[7:0]};
  endfunction

  task automatic issue_nl(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [3:0] code;
    logic [7:0] ad;
    logic       exp_err;
    code    = op[15:12];
    ad      = op[7:0];
    exp_err = (code > 4'd4);
    @(negedge clk);
    in_valid = 1'b1; opCode = op; A_in = a; B_in = b; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL nl_ready_pre op=%h in_ready=%b exp=1", op, in_ready); end
    @(posedge clk); #1;
    checks++;
    if (err !== exp_err) begin failures++; $display("FAIL nl_err op=%h err=%b exp=%b", op, err, exp_err); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL nl_ready_post op=%h in_ready=%b exp=1", op, in_ready); end
    if (code == 4'd2) mem_m[ad] = a;
    else if (code == 4'd3) mem_m[ad] = a + b;
  endtask

  task automatic issue_ld(input logic [15:0] op, input logic [15:0] b, input int hold);
    logic [3:0]  code;
    logic [7:0]  ad;
    logic [16:0] exp;
    code = op[15:12];
    ad   = op[7:0];
    exp  = (code == 4'd4) ? ({1'b0, mem_m[ad]} + {1'b0, b}) : {1'b0, mem_m[ad]};
    @(negedge clk);
    in_valid = 1'b1; opCode = op; A_in = 16'($urandom); B_in = b; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL ld_read op=%h out_valid=%b in_ready=%b exp=0/0", op, out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; B_in = 16'($urandom); opCode = 16'($urandom); out_ready = (hold == 0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || A_out !== exp[15:0] || carry_out !== exp[16]) begin
      failures++;
      $display("FAIL ld_result op=%h valid=%b A_out=%h carry=%b exp=1/%h/%b", op, out_valid, A_out, carry_out, exp[15:0], exp[16]);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      B_in = 16'($urandom); out_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || A_out !== exp[15:0] || carry_out !== exp[16] || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL ld_hold op=%h k=%0d valid=%b A_out=%h carry=%b in_ready=%b exp=1/%h/%b/0", op, k, out_valid, A_out, carry_out, in_ready, exp[15:0], exp[16]);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL ld_consume op=%h out_valid=%b in_ready=%b exp=0/1", op, out_valid, in_ready);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || A_out !== 16'h0 || err !== 1'b0 || carry_out !== 1'b0) begin
      failures++; $display("FAIL reset_outputs valid=%b A_out=%h err=%b carry=%b exp=0/0/0/0", out_valid, A_out, err, carry_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_st_ld();
    issue_nl(16'h2005, 16'h1234, 16'h0);
    issue_ld(16'h1005, 16'h5555, 0);
  endtask

  task automatic test_wrap();
    issue_nl(16'h30FF, 16'hFFFF, 16'h0002);
    go_idle();
    issue_ld(16'h10FF, 16'h0, 0);
    issue_ld(16'h40FF, 16'hFFFF, 0);
  endtask

  task automatic test_backpressure();
    issue_ld(16'h1005, 16'h0, 5);
  endtask

  task automatic test_illegal();
    issue_nl(16'hF005, 16'hDEAD, 16'h0);
    go_idle();
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear err=%b exp=0", err); end
    issue_ld(16'h1005, 16'h0, 0);
    issue_nl(16'h2305, 16'hBEEF, 16'h0);
    go_idle();
    issue_ld(16'h1005, 16'h0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) issue_nl(mk_op(2, i), 16'(i), 16'($urandom));
    go_idle();
    for (int i = 0; i < 256; i++) issue_ld(mk_op(1, i), 16'($urandom), 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int r;
      int code;
      int ad;
      r    = $urandom_range(0, 9);
      code = (r <= 4) ? r : $urandom_range(5, 15);
      ad   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(248, 255);
      if (code == 1 || code == 4)
        issue_ld(mk_op(code, ad), 16'($urandom), $urandom_range(0, 2));
      else
        issue_nl(mk_op(code, ad), 16'($urandom), 16'($urandom));
    end
    go_idle();
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    in_valid = 1'b1; opCode = 16'h1010; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL resp_reached out_valid=%b exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || A_out !== 16'h0 || carry_out !== 1'b0) begin
      failures++; $display("FAIL reset_in_resp valid=%b in_ready=%b A_out=%h carry=%b exp=0/1/0/0", out_valid, in_ready, A_out, carry_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_idle valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
    end
    issue_ld(16'h1010, 16'h0, 0);
  endtask

  initial begin
    test_reset();
    test_st_ld();
    test_wrap();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
